// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// State encodings and requester index constants used across the arbiter slice.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector with lock support.
// A held lock restricts the choice to the current owner.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic locked,
    input  logic owner,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = REQ_CPU;
        if (locked) begin
            grant_valid = (owner == REQ_AUX) ? req1 : req0;
            grant_idx   = owner;
        end else if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_idx   = ~last;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_idx   = REQ_CPU;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_idx   = REQ_AUX;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the CPU (req 0) and the loader/DMA (req 1).
// Round-robin arbitration, one transaction per three cycles, optional lock for read-then-write.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned BITS_DATA = 32,
    parameter int unsigned BITS_ADDR = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata0,
    input  logic [BITS_DATA-1:0] wdata1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic                 lock0,
    input  logic                 lock1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [BITS_DATA-1:0] rdata,
    output logic [BITS_ADDR-1:0] mem_addr,
    output logic [BITS_DATA-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [BITS_DATA-1:0] mem_rdata,
    output logic                 busy
);

    arb_state_e state_q, state_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d;
    logic mem_we_q, mem_we_d, busy_q, busy_d;
    logic [BITS_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [BITS_DATA-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic owner_q, owner_d, last_q, last_d, locked_q, locked_d;
    logic grant_valid, grant_idx;
    logic owner_we, owner_lock;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (last_q),
        .locked      (locked_q),
        .owner       (owner_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Request fields are held stable until ack, so they can be read again in DONE.
    assign owner_we   = (owner_q == REQ_AUX) ? we1 : we0;
    assign owner_lock = (owner_q == REQ_AUX) ? lock1 : lock0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            owner_q     <= REQ_CPU;
            last_q      <= REQ_AUX;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d = ARB_IDLE;
        case (state_q)
            ARB_IDLE:  state_d = grant_valid ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        locked_d    = locked_q;
        busy_d      = (state_d != ARB_IDLE);
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    owner_d     = grant_idx;
                    mem_addr_d  = (grant_idx == REQ_AUX) ? addr1 : addr0;
                    mem_wdata_d = (grant_idx == REQ_AUX) ? wdata1 : wdata0;
                    mem_we_d    = (grant_idx == REQ_AUX) ? we1 : we0;
                end
            end
            ARB_DONE: begin
                if (!owner_we) begin
                    rdata_d = mem_rdata;
                end
                ack0_d   = (owner_q == REQ_CPU);
                ack1_d   = (owner_q == REQ_AUX);
                last_d   = owner_q;
                locked_d = owner_lock;
            end
            default: ;
        endcase
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level scheduling model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  t_req = '0, t_we = '0, t_lock = '0;
    logic [15:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic        ack0, ack1, mem_we, busy;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [31:0] mem [65536];
    logic [31:0] mem_ref [65536];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one in-flight transaction at most.
    bit          m_active;
    int          m_owner, m_last, m_wait;
    bit          m_locked, m_txn_we, m_txn_lock;
    logic [15:0] m_txn_addr;
    logic [1:0]  e_ack;
    logic [31:0] e_rdata, e_wdata;
    logic [15:0] e_addr;
    logic        e_we, e_busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (t_req[0]),
        .req1      (t_req[1]),
        .addr0     (t_addr[0]),
        .addr1     (t_addr[1]),
        .wdata0    (t_wdata[0]),
        .wdata1    (t_wdata[1]),
        .we0       (t_we[0]),
        .we1       (t_we[1]),
        .lock0     (t_lock[0]),
        .lock1     (t_lock[1]),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_txn(input int i);
        if ($urandom_range(0, 3) == 0) t_addr[i] = 16'hFFF0 | 16'($urandom_range(0, 15));
        else t_addr[i] = 16'($urandom_range(0, 31));
        t_wdata[i] = $urandom;
        t_we[i]    = 1'($urandom_range(0, 1));
        t_lock[i]  = ($urandom_range(0, 3) == 0);
    endtask

    // Round-robin rule: a lock reserves the port for its owner, otherwise alternate on contention.
    function automatic int pick();
        if (m_locked) return t_req[m_owner] ? m_owner : -1;
        if (t_req == 2'b11) return 1 - m_last;
        if (t_req[0]) return 0;
        if (t_req[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_owner = 0; m_last = 1; m_locked = 0; m_wait = 0;
        e_ack = '0; e_rdata = '0; e_wdata = '0; e_addr = '0; e_we = 0; e_busy = 0;
    endtask

    // Predict DUT outputs after the coming clock edge.
    task automatic model_step();
        int g;
        if (reset) begin
            model_reset();
            return;
        end
        e_ack = '0;
        e_we  = 0;
        if (m_active) begin
            if (m_wait == 1) begin
                e_ack[m_owner] = 1'b1;
                if (!m_txn_we) e_rdata = mem_ref[m_txn_addr];
                m_last   = m_owner;
                m_locked = m_txn_lock;
                m_active = 0;
            end else begin
                m_wait--;
            end
        end else begin
            g = pick();
            if (g >= 0) begin
                m_active   = 1;
                m_owner    = g;
                m_wait     = 2;
                m_txn_addr = t_addr[g];
                m_txn_we   = t_we[g];
                m_txn_lock = t_lock[g];
                e_addr     = t_addr[g];
                e_wdata    = t_wdata[g];
                e_we       = t_we[g];
                if (t_we[g]) mem_ref[t_addr[g]] = t_wdata[g];
            end
        end
        e_busy = m_active;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = $urandom;
            mem_ref[a] = mem[a];
        end
        for (int i = 0; i < 2; i++) new_txn(i);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            check("ack0", 32'(ack0), 32'(e_ack[0]));
            check("ack1", 32'(ack1), 32'(e_ack[1]));
            check("rdata", rdata, e_rdata);
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_wdata", mem_wdata, e_wdata);
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("busy", 32'(busy), 32'(e_busy));

            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                t_req = '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (e_ack[i]) begin
                        if ($urandom_range(0, 1) == 0) t_req[i] = 1'b0;
                        else new_txn(i);
                    end else if (t_req[i]) begin
                        if (!(m_active && m_owner == i) && $urandom_range(0, 15) == 0)
                            t_req[i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        new_txn(i);
                        t_req[i] = 1'b1;
                    end
                end
            end
            model_step();
            @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (16-bit word address, 32-bit data, synchronous read) between two requesters: req 0 (CPU) and req 1 (loader/debug DMA).
- Serialises the two requesters with round-robin priority and a per-transaction req/ack handshake.
- Supports an optional lock that holds the port for an atomic read-then-write sequence.
- Sits between the CPU/loader and the memory module, replacing the direct CPU-to-memory wiring.

Parameters:
- BITS_DATA, 32, data word width.
- BITS_ADDR, 16, word address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- req0, req1  input  1 each  request; addr/wdata/we/lock must be held stable from assertion until the matching ack.
- addr0, addr1  input  BITS_ADDR each  word address.
- wdata0, wdata1  input  BITS_DATA each  write data.
- we0, we1  input  1 each  1 = write, 0 = read.
- lock0, lock1  input  1 each  keep the grant after this transaction.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata  output  BITS_DATA  read data; valid in the ack cycle, held until the next ack.
- mem_addr  output  BITS_ADDR  memory address.
- mem_wdata  output  BITS_DATA  memory write data.
- mem_we  output  1  memory write strobe.
- mem_rdata  input  BITS_DATA  memory read data, valid one cycle after mem_addr.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: ack0/ack1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, state=IDLE, last_grant=1 (requester 0 wins the first contest), owner=0, locked=0.
- Reset mid-transaction aborts with no ack; mem_we is deasserted on the next edge.
- FSM states are IDLE, ISSUE and DONE; all outputs are registered.
- IDLE:
  - If locked, only the owner's req is accepted; the other requester waits.
  - Otherwise, with a single requester asserting, grant it.
  - With both asserting, grant the one not equal to last_grant.
  - On grant: latch owner, drive mem_addr/mem_wdata from the owner, set mem_we=we(owner), go to ISSUE.
- ISSUE:
  - mem_we drops to 0 (the write strobe is exactly one cycle).
  - Go to DONE.
- DONE:
  - rdata <= mem_rdata on reads; unchanged on writes.
  - ack(owner)=1 for one cycle.
  - last_grant <= owner; locked <= lock(owner).
  - Go to IDLE.
- Latency: req sampled high in IDLE at edge t gives ack high after edge t+2. Throughput is one transaction per 3 cycles.
- A requester must drop req in the ack cycle or re-present it. If req is still high in the cycle after ack, it is a new transaction.
- While locked:
  - The non-owner's req is ignored indefinitely; there is no timeout.
  - Lock is released by a transaction from the owner with lock=0.
  - If the owner drops req while locked, the lock persists.
- Round robin: a requester that holds req continuously waits at most one foreign transaction when not locked.
- A req that drops before grant is not an error; nothing is issued.
- The address is used as given, with no wrap handling; the full 2^BITS_ADDR space is passed through.

Decomposition:
- Shared package (existing defines include file):
  - FSM state encodings ARB_IDLE=0, ARB_ISSUE=1, ARB_DONE=2.
  - Requester index constants REQ_CPU=0, REQ_AUX=1.
- Sub-module rr_pick2: combinational two-way round-robin selector (req0, req1, last, locked, owner -> grant_valid, grant_idx). It is natural to split out and test alone.
- Everything else stays in one module.

Test Plan:
- Single read: mem[0x0010]=0xDEADBEEF; req0 with addr0=0x0010, we0=0 at cycle 0 -> mem_addr=0x0010 after edge 1; ack0 and rdata=0xDEADBEEF after edge 3; ack1 never asserts.
- Single write: req1 with addr1=0x0200, wdata1=0x12345678, we1=1 -> mem_we high for exactly one cycle with mem_addr=0x0200 and mem_wdata=0x12345678; ack1 two cycles after the grant; a later read returns 0x12345678.
- Contention: req0 and req1 asserted together and held, re-presented after each ack, 4 transactions -> grant order 0,1,0,1 after reset; acks 3 cycles apart.
- Lock: req1 with lock1=1 reads 0x0005, then req1 writes 0x0005 with lock1=0, while req0 is held throughout -> both req1 transactions complete before ack0; req0 is served immediately after.
- Reset mid-op: assert reset in ISSUE of a write -> no ack; mem_we=0, busy=0 and all outputs at reset values after the edge; a fresh req0 then completes normally.
- Req withdrawn: pulse req0 for one cycle while req1 holds the port -> no ack0 and no memory access for requester 0.
